// File: rtl/latch_write_sequencer.sv
// rtl/latch_write_sequencer.sv - sequences D setup / one-hot EN pulse / D hold for a gated latch bank
module latch_write_sequencer #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 4,
    parameter int ADDR_W    = 2,
    parameter int SETUP_CYC = 1,
    parameter int PULSE_CYC = 2,
    parameter int HOLD_CYC  = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [WIDTH-1:0]  in_data,
    output logic [WIDTH-1:0]  lat_d,
    output logic [DEPTH-1:0]  lat_en,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int MAX_SP  = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
    localparam int MAX_CYC = (MAX_SP > HOLD_CYC) ? MAX_SP : HOLD_CYC;
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ENABLE,
        HOLD
    } state_t;

    state_t            state, state_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic [ADDR_W-1:0] addr_q, addr_n;
    logic [WIDTH-1:0]  d_n;
    logic [DEPTH-1:0]  en_n;
    logic              done_n, err_n;
    logic              accept, in_range;

    assign accept   = in_valid && in_ready;
    assign in_range = ({1'b0, in_addr} < (ADDR_W+1)'(DEPTH));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            addr_q   <= '0;
            lat_d    <= '0;
            lat_en   <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            in_ready <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            addr_q   <= addr_n;
            lat_d    <= d_n;
            lat_en   <= en_n;
            busy     <= (state_n != IDLE);
            done     <= done_n;
            err      <= err_n;
            in_ready <= (state_n == IDLE);
        end
    end

    // Each state's counter is loaded with its length minus one on entry and
    // the state is left on the cycle the counter reads zero.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        addr_n  = addr_q;
        d_n     = lat_d;
        done_n  = 1'b0;
        err_n   = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (in_range) begin
                        state_n = SETUP;
                        cnt_n   = CNT_W'(SETUP_CYC - 1);
                        addr_n  = in_addr;
                        d_n     = in_data;
                    end else begin
                        err_n = 1'b1;
                    end
                end
            end
            SETUP: begin
                if (cnt == '0) begin
                    state_n = ENABLE;
                    cnt_n   = CNT_W'(PULSE_CYC - 1);
                end else begin
                    cnt_n = cnt - CNT_W'(1);
                end
            end
            ENABLE: begin
                if (cnt == '0) begin
                    state_n = HOLD;
                    cnt_n   = CNT_W'(HOLD_CYC - 1);
                end else begin
                    cnt_n = cnt - CNT_W'(1);
                end
            end
            HOLD: begin
                if (cnt == '0) begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                end else begin
                    cnt_n = cnt - CNT_W'(1);
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // EN is decoded from the next state so it is registered alongside it and
    // is high exactly while the sequencer sits in ENABLE.
    always_comb begin
        en_n = '0;
        for (int i = 0; i < DEPTH; i++) begin
            en_n[i] = (state_n == ENABLE) && (addr_n == ADDR_W'(i));
        end
    end

endmodule

// File: tb/tb_latch_write_sequencer.sv
// tb/tb_latch_write_sequencer.sv - self-checking bench for latch_write_sequencer
module tb_latch_write_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Instance A: defaults
    logic       a_rst_n = 1'b0, a_in_valid = 1'b0, a_in_ready, a_busy, a_done, a_err;
    logic [1:0] a_in_addr = '0;
    logic [7:0] a_in_data = '0, a_lat_d;
    logic [3:0] a_lat_en;

    // Instance B: SETUP=3, PULSE=1, HOLD=2
    logic       b_rst_n = 1'b0, b_in_valid = 1'b0, b_in_ready, b_busy, b_done, b_err;
    logic [1:0] b_in_addr = '0;
    logic [7:0] b_in_data = '0, b_lat_d;
    logic [3:0] b_lat_en;

    // Instance C: DEPTH=3, default timing
    logic       c_rst_n = 1'b0, c_in_valid = 1'b0, c_in_ready, c_busy, c_done, c_err;
    logic [1:0] c_in_addr = '0;
    logic [7:0] c_in_data = '0, c_lat_d;
    logic [2:0] c_lat_en;

    latch_write_sequencer u_a (
        .clk(clk), .rst_n(a_rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_addr(a_in_addr), .in_data(a_in_data), .lat_d(a_lat_d), .lat_en(a_lat_en),
        .busy(a_busy), .done(a_done), .err(a_err)
    );

    latch_write_sequencer #(.SETUP_CYC(3), .PULSE_CYC(1), .HOLD_CYC(2)) u_b (
        .clk(clk), .rst_n(b_rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_addr(b_in_addr), .in_data(b_in_data), .lat_d(b_lat_d), .lat_en(b_lat_en),
        .busy(b_busy), .done(b_done), .err(b_err)
    );

    latch_write_sequencer #(.DEPTH(3)) u_c (
        .clk(clk), .rst_n(c_rst_n), .in_valid(c_in_valid), .in_ready(c_in_ready),
        .in_addr(c_in_addr), .in_data(c_in_data), .lat_d(c_lat_d), .lat_en(c_lat_en),
        .busy(c_busy), .done(c_done), .err(c_err)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        #1;
        checks++;
        if ({a_lat_en, a_lat_d, a_busy, a_done, a_err, a_in_ready} !== 16'h0) begin
            errors++;
            $display("FAIL reset_values: en=%b d=%h busy=%b done=%b err=%b rdy=%b, want all 0",
                     a_lat_en, a_lat_d, a_busy, a_done, a_err, a_in_ready);
        end
        tick; tick;
        a_rst_n = 1'b1; b_rst_n = 1'b1; c_rst_n = 1'b1;
        checks++;
        if (a_in_ready !== 1'b0) begin
            errors++;
            $display("FAIL ready_before_edge: got %b want 0", a_in_ready);
        end
        tick;
        checks++;
        if (a_in_ready !== 1'b1 || b_in_ready !== 1'b1 || c_in_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_release: got a=%b b=%b c=%b want 1", a_in_ready, b_in_ready, c_in_ready);
        end
    endtask

    task automatic test_single_write;
        logic [3:0] exp_en;
        a_in_valid = 1'b1; a_in_addr = 2'd2; a_in_data = 8'hA5;
        tick;
        a_in_valid = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            exp_en = (k == 2 || k == 3) ? 4'b0100 : 4'b0000;
            checks++;
            if (a_lat_en !== exp_en || a_lat_d !== 8'hA5) begin
                errors++;
                $display("FAIL single_en_d t+%0d: en=%b d=%h want en=%b d=a5", k, a_lat_en, a_lat_d, exp_en);
            end
            checks++;
            if (a_done !== (k == 5) || a_in_ready !== (k >= 5) || a_busy !== (k < 5)) begin
                errors++;
                $display("FAIL single_ctl t+%0d: done=%b rdy=%b busy=%b want %b %b %b",
                         k, a_done, a_in_ready, a_busy, k == 5, k >= 5, k < 5);
            end
            tick;
        end
    endtask

    task automatic test_back_to_back;
        a_in_valid = 1'b1; a_in_addr = 2'd0; a_in_data = 8'h11;
        tick;
        a_in_addr = 2'd3; a_in_data = 8'h22;
        for (int k = 1; k <= 10; k++) begin
            if (k <= 5) begin
                checks++;
                if (a_in_ready !== (k == 5) || a_done !== (k == 5)) begin
                    errors++;
                    $display("FAIL b2b_ready t+%0d: rdy=%b done=%b want %b", k, a_in_ready, a_done, k == 5);
                end
            end
            if (k == 6) begin
                a_in_valid = 1'b0;
                checks++;
                if (a_lat_d !== 8'h22 || a_busy !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_second_accept: d=%h busy=%b want 22 1", a_lat_d, a_busy);
                end
            end
            if (k == 7 || k == 8) begin
                checks++;
                if (a_lat_en !== 4'b1000) begin
                    errors++;
                    $display("FAIL b2b_en t+%0d: got %b want 1000", k, a_lat_en);
                end
            end
            if (k >= 6) begin
                checks++;
                if (a_lat_en[0] !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_bit0 t+%0d: en=%b want bit0 0", k, a_lat_en);
                end
            end
            tick;
        end
    endtask

    task automatic test_timing_params;
        logic [7:0] d;
        logic [3:0] exp_en;
        d = 8'($urandom);
        b_in_valid = 1'b1; b_in_addr = 2'd1; b_in_data = d;
        tick;
        b_in_valid = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            exp_en = (k == 4) ? 4'b0010 : 4'b0000;
            checks++;
            if (b_lat_en !== exp_en || b_done !== (k == 7)) begin
                errors++;
                $display("FAIL timing t+%0d: en=%b done=%b want en=%b done=%b", k, b_lat_en, b_done, exp_en, k == 7);
            end
            checks++;
            if (b_lat_d !== d) begin
                errors++;
                $display("FAIL timing_d t+%0d: got %h want %h", k, b_lat_d, d);
            end
            tick;
        end
    endtask

    task automatic test_out_of_range;
        c_in_valid = 1'b1; c_in_addr = 2'd3; c_in_data = 8'h5A;
        tick;
        c_in_valid = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            checks++;
            if (c_err !== (k == 1) || c_lat_en !== 3'b000 || c_in_ready !== 1'b1 ||
                c_done !== 1'b0 || c_lat_d !== 8'h00) begin
                errors++;
                $display("FAIL oor t+%0d: err=%b en=%b rdy=%b done=%b d=%h want err=%b en=0 rdy=1 done=0 d=0",
                         k, c_err, c_lat_en, c_in_ready, c_done, c_lat_d, k == 1);
            end
            tick;
        end
    endtask

    task automatic test_reset_mid_enable;
        logic seen_done;
        a_in_valid = 1'b1; a_in_addr = 2'd2; a_in_data = 8'h3C;
        tick;
        a_in_valid = 1'b0;
        tick;
        checks++;
        if (a_lat_en !== 4'b0100) begin
            errors++;
            $display("FAIL mid_pre: en=%b want 0100", a_lat_en);
        end
        #2 a_rst_n = 1'b0;
        #1;
        checks++;
        if (a_lat_en !== 4'b0000 || a_lat_d !== 8'h00) begin
            errors++;
            $display("FAIL mid_async: en=%b d=%h want 0 0", a_lat_en, a_lat_d);
        end
        seen_done = 1'b0;
        tick;
        seen_done |= a_done;
        a_rst_n = 1'b1;
        checks++;
        if (a_in_ready !== 1'b0) begin
            errors++;
            $display("FAIL mid_ready_early: got %b want 0", a_in_ready);
        end
        tick;
        checks++;
        if (a_in_ready !== 1'b1) begin
            errors++;
            $display("FAIL mid_ready_release: got %b want 1", a_in_ready);
        end
        for (int k = 0; k < 6; k++) begin
            seen_done |= a_done;
            tick;
        end
        checks++;
        if (seen_done !== 1'b0 || a_lat_en !== 4'b0000) begin
            errors++;
            $display("FAIL mid_no_done: done_seen=%b en=%b want 0 0", seen_done, a_lat_en);
        end
    endtask

    // Model: position within a sequence counted as cycles since acceptance.
    task automatic test_random;
        int reqs = 0, k = 0, cyc = 0, n_acc = 0, n_done = 0;
        logic v, acc, rdy_m, exp_done, exp_err;
        logic [1:0] a, exp_a;
        logic [7:0] d, exp_d, prev_d;
        logic [2:0] exp_en, prev_en;
        rdy_m = 1'b1; exp_d = 8'h00; exp_a = 2'd0;
        prev_d = c_lat_d; prev_en = c_lat_en;
        while ((reqs < 1000 || k != 0) && cyc < 20000) begin
            v = (reqs < 1000) ? 1'($urandom_range(0, 1)) : 1'b0;
            a = 2'($urandom_range(0, 3));
            d = 8'($urandom);
            c_in_valid = v; c_in_addr = a; c_in_data = d;
            acc = v && rdy_m;
            tick;
            cyc++;
            exp_done = 1'b0; exp_err = 1'b0;
            if (acc) reqs++;
            if (acc && a < 2'd3) begin
                k = 1; exp_d = d; exp_a = a; n_acc++;
            end else begin
                if (acc) exp_err = 1'b1;
                if (k > 0) begin
                    k++;
                    if (k == 5) begin
                        k = 0; exp_done = 1'b1;
                    end
                end
            end
            exp_en = (k >= 2 && k <= 3) ? 3'(1 << exp_a) : 3'b000;
            rdy_m = (k == 0);
            if (c_done) n_done++;
            checks++;
            if (c_lat_en !== exp_en || c_lat_d !== exp_d || c_done !== exp_done || c_err !== exp_err ||
                c_in_ready !== rdy_m || c_busy !== !rdy_m) begin
                errors++;
                $display("FAIL rand cyc %0d: en=%b d=%h done=%b err=%b rdy=%b busy=%b want %b %h %b %b %b %b",
                         cyc, c_lat_en, c_lat_d, c_done, c_err, c_in_ready, c_busy,
                         exp_en, exp_d, exp_done, exp_err, rdy_m, !rdy_m);
            end
            checks++;
            if ($countones(c_lat_en) > 1) begin
                errors++;
                $display("FAIL rand_onehot cyc %0d: en=%b want <=1 bit", cyc, c_lat_en);
            end
            checks++;
            if ((prev_en != 3'b000 || c_lat_en != 3'b000) && c_lat_d !== prev_d) begin
                errors++;
                $display("FAIL rand_d_stable cyc %0d: d=%h was %h with en=%b/%b", cyc, c_lat_d, prev_d, prev_en, c_lat_en);
            end
            prev_d = c_lat_d; prev_en = c_lat_en;
        end
        c_in_valid = 1'b0;
        checks++;
        if (cyc >= 20000) begin
            errors++;
            $display("FAIL rand_timeout: reqs=%0d want 1000 within budget", reqs);
        end
        checks++;
        if (n_done != n_acc) begin
            errors++;
            $display("FAIL rand_done_count: done=%0d want %0d", n_done, n_acc);
        end
    endtask

    initial begin
        test_reset;
        test_single_write;
        test_back_to_back;
        test_timing_params;
        test_out_of_range;
        test_reset_mid_enable;
        test_random;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
